// File: rtl/fetch_queue_pkg.sv
// Shared widths for the fetch queue: the bundle field sizes and the packed entry width.
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef INSN_LEN
`define INSN_LEN 32
`endif
`ifndef GSH_BHR_LEN
`define GSH_BHR_LEN 10
`endif

package fetch_queue_pkg;
  localparam int ADDR_W  = `ADDR_LEN;
  localparam int INSN_W  = `INSN_LEN;
  localparam int BHR_W   = `GSH_BHR_LEN;
  // pc + npc + inst1 + inst2 + bhr + invalid2 + predict_cond
  localparam int ENTRY_W = 2*ADDR_W + 2*INSN_W + BHR_W + 2;
endpackage

// File: rtl/fq_ptr_ctrl.sv
// Head/tail pointer control for the fetch queue. Pointers carry an extra wrap
// bit so full and empty are distinguishable without a separate counter.
module fq_ptr_ctrl #(
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_enq_valid,
  input  logic             i_deq_ready,
  output logic             o_enq_ready,
  output logic             o_deq_valid,
  output logic             o_enq_fire,
  output logic             o_deq_fire,
  output logic [PTR_W-1:0] o_head_idx,
  output logic [PTR_W-1:0] o_tail_idx,
  output logic [PTR_W:0]   o_count
);
  import fetch_queue_pkg::*;

  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [PTR_W:0] r_head;
  logic [PTR_W:0] r_tail;
  logic           w_full;
  logic           w_empty;

  // Full when pointers match on the index bits but sit on opposite laps.
  assign w_empty = (r_head == r_tail);
  assign w_full  = (r_head[PTR_W] != r_tail[PTR_W]) &&
                   (r_head[PTR_W-1:0] == r_tail[PTR_W-1:0]);

  // Ready/valid come from pointer state only, never from the partner handshake.
  assign o_enq_ready = !w_full;
  assign o_deq_valid = !w_empty;
  assign o_enq_fire  = i_enq_valid && o_enq_ready && !i_flush;
  assign o_deq_fire  = o_deq_valid && i_deq_ready && !i_flush;

  assign o_head_idx = r_head[PTR_W-1:0];
  assign o_tail_idx = r_tail[PTR_W-1:0];
  assign o_count    = r_tail - r_head;

  // Pointer update: flush dominates, otherwise each side advances on its own fire.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (i_flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (o_enq_fire) r_tail <= r_tail + PTR_ONE;
      if (o_deq_fire) r_head <= r_head + PTR_ONE;
    end
  end
endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO. Stores fetched bundles with their prediction
// metadata and presents the oldest one to decode; emptied on misprediction.
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef INSN_LEN
`define INSN_LEN 32
`endif
`ifndef GSH_BHR_LEN
`define GSH_BHR_LEN 10
`endif

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    enq_valid,
  output logic                    enq_ready,
  input  logic [`ADDR_LEN-1:0]    enq_pc,
  input  logic [`ADDR_LEN-1:0]    enq_npc,
  input  logic [`INSN_LEN-1:0]    enq_inst1,
  input  logic [`INSN_LEN-1:0]    enq_inst2,
  input  logic                    enq_invalid2,
  input  logic                    enq_predict_cond,
  input  logic [`GSH_BHR_LEN-1:0] enq_bhr,
  output logic                    deq_valid,
  input  logic                    deq_ready,
  output logic [`ADDR_LEN-1:0]    deq_pc,
  output logic [`ADDR_LEN-1:0]    deq_npc,
  output logic [`INSN_LEN-1:0]    deq_inst1,
  output logic [`INSN_LEN-1:0]    deq_inst2,
  output logic                    deq_invalid2,
  output logic                    deq_predict_cond,
  output logic [`GSH_BHR_LEN-1:0] deq_bhr,
  output logic [PTR_W:0]          count
);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [ENTRY_W-1:0] w_enq_data;
  logic [ENTRY_W-1:0] w_head_data;
  logic               w_enq_fire;
  logic               w_deq_fire;
  logic [PTR_W-1:0]   w_head_idx;
  logic [PTR_W-1:0]   w_tail_idx;

  fq_ptr_ctrl #(
    .PTR_W (PTR_W)
  ) u_ptr_ctrl (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (flush),
    .i_enq_valid (enq_valid),
    .i_deq_ready (deq_ready),
    .o_enq_ready (enq_ready),
    .o_deq_valid (deq_valid),
    .o_enq_fire  (w_enq_fire),
    .o_deq_fire  (w_deq_fire),
    .o_head_idx  (w_head_idx),
    .o_tail_idx  (w_tail_idx),
    .o_count     (count)
  );

  assign w_enq_data = {enq_pc, enq_npc, enq_inst1, enq_inst2,
                       enq_bhr, enq_invalid2, enq_predict_cond};

  // Entry storage: cleared on reset, written at tail on an accepted enqueue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_enq_fire) begin
      r_mem[w_tail_idx] <= w_enq_data;
    end
  end

  // Head entry straight from storage; a new bundle is visible one cycle after it is written.
  assign w_head_data = r_mem[w_head_idx];
  assign {deq_pc, deq_npc, deq_inst1, deq_inst2,
          deq_bhr, deq_invalid2, deq_predict_cond} = w_head_data;

  // Dequeue acceptance only moves the head pointer; nothing else to do with it here.
  logic w_unused;
  assign w_unused = w_deq_fire;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue: one task per scenario, inline checks.
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef INSN_LEN
`define INSN_LEN 32
`endif
`ifndef GSH_BHR_LEN
`define GSH_BHR_LEN 10
`endif

module tb_fetch_queue;
  logic                    clk;
  logic                    reset;
  logic                    flush;
  logic                    enq_valid;
  logic                    enq_ready;
  logic [`ADDR_LEN-1:0]    enq_pc;
  logic [`ADDR_LEN-1:0]    enq_npc;
  logic [`INSN_LEN-1:0]    enq_inst1;
  logic [`INSN_LEN-1:0]    enq_inst2;
  logic                    enq_invalid2;
  logic                    enq_predict_cond;
  logic [`GSH_BHR_LEN-1:0] enq_bhr;
  logic                    deq_valid;
  logic                    deq_ready;
  logic [`ADDR_LEN-1:0]    deq_pc;
  logic [`ADDR_LEN-1:0]    deq_npc;
  logic [`INSN_LEN-1:0]    deq_inst1;
  logic [`INSN_LEN-1:0]    deq_inst2;
  logic                    deq_invalid2;
  logic                    deq_predict_cond;
  logic [`GSH_BHR_LEN-1:0] deq_bhr;
  logic [2:0]              count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .enq_valid        (enq_valid),
    .enq_ready        (enq_ready),
    .enq_pc           (enq_pc),
    .enq_npc          (enq_npc),
    .enq_inst1        (enq_inst1),
    .enq_inst2        (enq_inst2),
    .enq_invalid2     (enq_invalid2),
    .enq_predict_cond (enq_predict_cond),
    .enq_bhr          (enq_bhr),
    .deq_valid        (deq_valid),
    .deq_ready        (deq_ready),
    .deq_pc           (deq_pc),
    .deq_npc          (deq_npc),
    .deq_inst1        (deq_inst1),
    .deq_inst2        (deq_inst2),
    .deq_invalid2     (deq_invalid2),
    .deq_predict_cond (deq_predict_cond),
    .deq_bhr          (deq_bhr),
    .count            (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    enq_valid = 1'b1;
    enq_pc = 32'h0000_0abc;
    enq_inst1 = 32'h1234_5678;
    repeat (3) step();
    n_checks++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_deq_valid got=%b exp=0", deq_valid); end
    n_checks++; if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL reset_enq_ready got=%b exp=1", enq_ready); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_checks++; if ({deq_pc, deq_npc, deq_inst1, deq_inst2, deq_bhr, deq_invalid2, deq_predict_cond} !== '0) begin
      n_fail++; $display("FAIL reset_deq_fields got pc=%h inst1=%h exp all zero", deq_pc, deq_inst1);
    end
    reset = 1'b1;
    enq_pc = 32'h100;
    enq_inst1 = 32'h0000_0013;
    step();
    enq_valid = 1'b0;
    n_checks++; if (deq_valid !== 1'b1) begin n_fail++; $display("FAIL first_enq_valid got=%b exp=1", deq_valid); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL first_enq_count got=%0d exp=1", count); end
    n_checks++; if (deq_pc !== 32'h100) begin n_fail++; $display("FAIL first_enq_pc got=%h exp=100", deq_pc); end
    n_checks++; if (deq_inst1 !== 32'h13) begin n_fail++; $display("FAIL first_enq_inst1 got=%h exp=00000013", deq_inst1); end
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL first_deq_count got=%0d exp=0", count); end
    $display("test_reset done");
  endtask

  task automatic test_fill();
    logic [31:0] exp_pc [5];
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h8; exp_pc[2] = 32'h10; exp_pc[3] = 32'h18; exp_pc[4] = 32'h20;
    deq_ready = 1'b0;
    enq_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      enq_pc = exp_pc[i];
      step();
    end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count got=%0d exp=4", count); end
    n_checks++; if (enq_ready !== 1'b0) begin n_fail++; $display("FAIL fill_enq_ready got=%b exp=0", enq_ready); end
    enq_pc = exp_pc[4];
    step();
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_hold_count got=%0d exp=4", count); end
    deq_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (deq_valid !== 1'b1 || deq_pc !== exp_pc[i]) begin
        n_fail++; $display("FAIL drain_%0d got valid=%b pc=%h exp valid=1 pc=%h", i, deq_valid, deq_pc, exp_pc[i]);
      end
      step();
      if (i == 0) begin
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL drain_full_deq_count got=%0d exp=3", count); end
      end
      if (i == 1) begin
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL drain_fifth_accept_count got=%0d exp=3", count); end
        enq_valid = 1'b0;
      end
    end
    n_checks++; if (deq_valid !== 1'b0 || count !== 3'd0) begin
      n_fail++; $display("FAIL drain_empty got valid=%b count=%0d exp valid=0 count=0", deq_valid, count);
    end
    deq_ready = 1'b0;
    $display("test_fill done");
  endtask

  task automatic test_stream();
    logic [31:0] base;
    base = 32'h1000;
    deq_ready = 1'b1;
    enq_valid = 1'b1;
    enq_pc = base;
    step();
    for (int k = 1; k <= 20; k++) begin
      enq_pc = base + 32'(8 * k);
      n_checks++; if (deq_valid !== 1'b1 || deq_pc !== base + 32'(8 * (k - 1))) begin
        n_fail++; $display("FAIL stream_%0d got valid=%b pc=%h exp valid=1 pc=%h", k, deq_valid, deq_pc, base + 32'(8 * (k - 1)));
      end
      step();
      n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL stream_count_%0d got=%0d exp=1", k, count); end
    end
    enq_valid = 1'b0;
    n_checks++; if (deq_pc !== base + 32'(8 * 20)) begin n_fail++; $display("FAIL stream_last got=%h exp=%h", deq_pc, base + 32'(8 * 20)); end
    step();
    n_checks++; if (count !== 3'd0 || deq_valid !== 1'b0) begin
      n_fail++; $display("FAIL stream_empty got valid=%b count=%0d exp valid=0 count=0", deq_valid, count);
    end
    deq_ready = 1'b0;
    $display("test_stream done");
  endtask

  task automatic test_flush();
    deq_ready = 1'b0;
    enq_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      enq_pc = 32'h300 + 32'(8 * i);
      step();
    end
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL preflush_count got=%0d exp=3", count); end
    flush = 1'b1;
    enq_pc = 32'h318;
    deq_ready = 1'b1;
    step();
    flush = 1'b0;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count got=%0d exp=0", count); end
    n_checks++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL flush_deq_valid got=%b exp=0", deq_valid); end
    enq_valid = 1'b1;
    enq_pc = 32'h400;
    step();
    enq_valid = 1'b0;
    n_checks++; if (deq_pc !== 32'h400 || count !== 3'd1) begin
      n_fail++; $display("FAIL postflush_head got pc=%h count=%0d exp pc=400 count=1", deq_pc, count);
    end
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    n_checks++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL postflush_empty got=%b exp=0", deq_valid); end
    $display("test_flush done");
  endtask

  task automatic test_fields();
    enq_valid = 1'b1;
    enq_pc = 32'h500;
    enq_npc = 32'h2000;
    enq_inst1 = 32'hcafe_f00d;
    enq_inst2 = 32'hdead_beef;
    enq_invalid2 = 1'b1;
    enq_predict_cond = 1'b1;
    enq_bhr = '1;
    step();
    enq_valid = 1'b0;
    enq_invalid2 = 1'b0;
    enq_predict_cond = 1'b0;
    enq_bhr = '0;
    n_checks++; if (deq_npc !== 32'h2000) begin n_fail++; $display("FAIL field_npc got=%h exp=00002000", deq_npc); end
    n_checks++; if (deq_inst2 !== 32'hdead_beef) begin n_fail++; $display("FAIL field_inst2 got=%h exp=deadbeef", deq_inst2); end
    n_checks++; if (deq_inst1 !== 32'hcafe_f00d) begin n_fail++; $display("FAIL field_inst1 got=%h exp=cafef00d", deq_inst1); end
    n_checks++; if (deq_invalid2 !== 1'b1) begin n_fail++; $display("FAIL field_invalid2 got=%b exp=1", deq_invalid2); end
    n_checks++; if (deq_predict_cond !== 1'b1) begin n_fail++; $display("FAIL field_predict got=%b exp=1", deq_predict_cond); end
    n_checks++; if (deq_bhr !== {`GSH_BHR_LEN{1'b1}}) begin n_fail++; $display("FAIL field_bhr got=%h exp=all ones", deq_bhr); end
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    $display("test_fields done");
  endtask

  task automatic test_async_reset();
    enq_valid = 1'b1;
    enq_pc = 32'h600;
    step();
    enq_pc = 32'h608;
    step();
    enq_valid = 1'b0;
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL prereset_count got=%0d exp=2", count); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (deq_valid !== 1'b0 || count !== 3'd0 || enq_ready !== 1'b1) begin
      n_fail++; $display("FAIL async_reset got valid=%b count=%0d ready=%b exp 0/0/1", deq_valid, count, enq_ready);
    end
    n_checks++; if (deq_pc !== 32'h0) begin n_fail++; $display("FAIL async_reset_pc got=%h exp=0", deq_pc); end
    reset = 1'b1;
    step();
    n_checks++; if (deq_valid !== 1'b0 || count !== 3'd0) begin
      n_fail++; $display("FAIL after_async_reset got valid=%b count=%0d exp 0/0", deq_valid, count);
    end
    $display("test_async_reset done");
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    enq_pc = '0;
    enq_npc = '0;
    enq_inst1 = '0;
    enq_inst2 = '0;
    enq_invalid2 = 1'b0;
    enq_predict_cond = 1'b0;
    enq_bhr = '0;
    #1;
    test_reset();
    test_fill();
    test_stream();
    test_flush();
    test_fields();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
